// File: rtl/wb_pkg.sv
// Shared widths, address step, FSM encoding and command payload for the Wishbone burst initiator.
package wb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned TMO_W  = 16;

  localparam logic [ADDR_W-1:0] WB_ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
    logic [LEN_W-1:0]  len;
  } cmd_t;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Loadable down-counter with a zero flag; bounds how long a bus request waits for ack.
module wb_timeout_ctr
  import wb_pkg::*;
#(
  parameter logic [TMO_W-1:0] LOAD_VAL = TMO_W'(254)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero_c
);

  logic [TMO_W-1:0] count;

  // Load on request entry, otherwise count down and saturate at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - TMO_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/wb_burst_initiator.sv
// Wishbone initiator that turns one command into len+1 single-beat bus cycles with per-beat responses.
module wb_burst_initiator
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              rsp_last_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              busy_o
);

  state_e           state;
  logic [LEN_W-1:0] beat_cnt;
  cmd_t             cmd_c;
  logic             tmo_load_c;
  logic             tmo_dec_c;
  logic             tmo_zero_c;

  assign cmd_c = '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i, sel: cmd_sel_i, len: cmd_len_i};

  // The counter is reloaded on every transition into REQ and only runs while waiting for ack.
  assign tmo_load_c = ((state == ST_IDLE) && cmd_valid_i) || (state == ST_GAP);
  assign tmo_dec_c  = (state == ST_REQ) && !wbm_ack_i && !tmo_zero_c;

  wb_timeout_ctr #(
    .LOAD_VAL (TMO_W'(TIMEOUT - 1))
  ) u_tmo (
    .clk    (wb_clk_i),
    .rst_n  (wb_rstn_i),
    .load   (tmo_load_c),
    .dec    (tmo_dec_c),
    .zero_c (tmo_zero_c)
  );

  // Burst sequencer: state and every registered output.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state       <= ST_IDLE;
      beat_cnt    <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      rsp_last_o  <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            wbm_we_o    <= cmd_c.we;
            wbm_adr_o   <= cmd_c.adr;
            wbm_dat_o   <= cmd_c.dat;
            wbm_sel_o   <= cmd_c.sel;
            beat_cnt    <= cmd_c.len;
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          // An ack on the final counter cycle still wins over the abort.
          if (wbm_ack_i) begin
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_last_o  <= (beat_cnt == '0);
            state       <= ST_RESP;
          end else if (tmo_zero_c) begin
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b1;
            rsp_last_o  <= 1'b1;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            if (rsp_last_o || rsp_err_o) begin
              wbm_cyc_o   <= 1'b0;
              busy_o      <= 1'b0;
              cmd_ready_o <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              beat_cnt  <= beat_cnt - LEN_W'(1);
              wbm_adr_o <= wbm_adr_o + WB_ADDR_STEP;
              state     <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          wbm_stb_o <= 1'b1;
          state     <= ST_REQ;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_initiator.sv
// Randomized scoreboard bench for wb_burst_initiator with a behavioural Wishbone responder.
module tb_wb_burst_initiator;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;
  logic        wbm_cyc;
  logic        wbm_stb;
  logic        wbm_we;
  logic [3:0]  wbm_sel;
  logic [31:0] wbm_adr;
  logic [31:0] wbm_dat;
  logic        wbm_ack = 1'b0;
  logic [31:0] wbm_dati = '0;
  logic        busy;

  wb_burst_initiator #(.TIMEOUT(TMO)) dut (
    .wb_clk_i    (clk),
    .wb_rstn_i   (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .cmd_len_i   (cmd_len),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .rsp_last_o  (rsp_last),
    .wbm_cyc_o   (wbm_cyc),
    .wbm_stb_o   (wbm_stb),
    .wbm_we_o    (wbm_we),
    .wbm_sel_o   (wbm_sel),
    .wbm_adr_o   (wbm_adr),
    .wbm_dat_o   (wbm_dat),
    .wbm_ack_i   (wbm_ack),
    .wbm_dat_i   (wbm_dati),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          run;
  } bus_exp_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        last;
  } rsp_exp_t;

  typedef struct {
    int          dly;
    logic [31:0] dat;
  } beat_t;

  bus_exp_t    bus_q[$];
  rsp_exp_t    rsp_q[$];
  beat_t       resp_q[$];

  int          total = 0;
  int          bad = 0;
  int          dly_a[256];
  logic [31:0] rdat_a[256];
  int          ready_pct = 100;
  int          stall_cnt = 0;
  bit          spurious = 1'b0;
  int          bus_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got nothing want an event", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_ctl"}, 64'({wbm_cyc, wbm_stb, wbm_we, wbm_sel}), 64'(0));
    check({tag, "_bus_adr"}, 64'(wbm_adr), 64'(0));
    check({tag, "_bus_dat"}, 64'(wbm_dat), 64'(0));
    check({tag, "_rsp_ctl"}, 64'({rsp_valid, rsp_err, rsp_last, busy}), 64'(0));
    check({tag, "_rsp_dat"}, 64'(rsp_dat), 64'(0));
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask

  // Responder: per-beat ack delay and read data come from resp_q; optional stray acks when stb is low.
  beat_t cur;
  bit    have = 1'b0;
  int    wcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      wbm_ack = 1'b0;
      have    = 1'b0;
      wcnt    = 0;
    end else if (wbm_cyc && wbm_stb) begin
      if (!have && resp_q.size() > 0) begin
        cur  = resp_q.pop_front();
        have = 1'b1;
        wcnt = 0;
      end
      wbm_ack  = have && (wcnt == cur.dly);
      wbm_dati = wbm_ack ? cur.dat : $urandom;
      wcnt++;
    end else begin
      have     = 1'b0;
      wbm_ack  = spurious && ($urandom_range(2) == 0);
      wbm_dati = $urandom;
    end
  end

  // Bus monitor: each stb-high run is one beat; compare its attributes and length.
  int       run = 0;
  bus_exp_t cb;
  bus_exp_t eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else if (wbm_stb) begin
      if (run == 0) begin
        cb.adr = wbm_adr;
        cb.we  = wbm_we;
        cb.sel = wbm_sel;
        cb.dat = wbm_dat;
      end
      run++;
      check("cyc_with_stb", 64'(wbm_cyc), 64'(1));
    end else if (run > 0) begin
      cb.run = run;
      run    = 0;
      bus_done++;
      if (bus_q.size() == 0) begin
        note_fail("bus_unexpected");
      end else begin
        eb = bus_q.pop_front();
        check("bus_adr", 64'(cb.adr), 64'(eb.adr));
        check("bus_we", 64'(cb.we), 64'(eb.we));
        check("bus_sel", 64'(cb.sel), 64'(eb.sel));
        if (eb.we) check("bus_wdat", 64'(cb.dat), 64'(eb.dat));
        check("bus_stb_cycles", 64'(cb.run), 64'(eb.run));
      end
    end
  end

  // Response monitor: drives rsp_ready, checks stability under back-pressure, pops the scoreboard.
  bit          held = 1'b0;
  bit          idle_chk = 1'b0;
  logic [31:0] h_dat;
  logic        h_err;
  logic        h_last;
  rsp_exp_t    er;
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_ready = 1'b0;
      held      = 1'b0;
      idle_chk  = 1'b0;
    end else begin
      if (held) begin
        check("rsp_stable", 64'({rsp_valid, rsp_err, rsp_last, rsp_dat}),
              64'({1'b1, h_err, h_last, h_dat}));
        check("stb_low_in_stall", 64'(wbm_stb), 64'(0));
      end
      if (idle_chk) begin
        check("idle_after_last", 64'({busy, wbm_cyc, cmd_ready}), 64'({1'b0, 1'b0, 1'b1}));
        idle_chk = 1'b0;
      end
      if (stall_cnt > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        stall_cnt--;
      end else begin
        rsp_ready = ($urandom_range(99) < ready_pct);
      end
      held = 1'b0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (rsp_q.size() == 0) begin
            note_fail("rsp_unexpected");
          end else begin
            er = rsp_q.pop_front();
            check("rsp_dat", 64'(rsp_dat), 64'(er.dat));
            check("rsp_err_last", 64'({rsp_err, rsp_last}), 64'({er.err, er.last}));
            if (er.err) check("cyc_low_on_abort", 64'(wbm_cyc), 64'(0));
            if (er.last) idle_chk = 1'b1;
          end
        end else begin
          held   = 1'b1;
          h_dat  = rsp_dat;
          h_err  = rsp_err;
          h_last = rsp_last;
        end
      end
    end
  end

  // Reference model: beat i goes to adr+4*i; a beat whose ack delay reaches TMO aborts the burst.
  task automatic start_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [7:0] len);
    int       n;
    bus_exp_t b;
    rsp_exp_t r;
    beat_t    t;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) note_fail("cmd_ready_wait");
    for (int i = 0; i <= int'(len); i++) begin
      b.adr = adr + 32'(4 * i);
      b.we  = we;
      b.sel = sel;
      b.dat = dat;
      b.run = (dly_a[i] < TMO) ? dly_a[i] + 1 : TMO;
      bus_q.push_back(b);
      t.dly = dly_a[i];
      t.dat = rdat_a[i];
      resp_q.push_back(t);
      if (dly_a[i] >= TMO) begin
        r.dat  = '0;
        r.err  = 1'b1;
        r.last = 1'b1;
        rsp_q.push_back(r);
        break;
      end
      r.dat  = we ? 32'h0 : rdat_a[i];
      r.err  = 1'b0;
      r.last = (i == int'(len));
      rsp_q.push_back(r);
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      note_fail("idle_wait");
      rsp_q.delete();
      bus_q.delete();
      resp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int b0;
    int n;
    for (int i = 0; i < 256; i++) begin
      dly_a[i]  = 0;
      rdat_a[i] = '0;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_release_ready", 64'({cmd_ready, busy}), 64'({1'b1, 1'b0}));

    // Single read, ack after one wait cycle.
    dly_a[0] = 1;
    rdat_a[0] = 32'h1234_5678;
    start_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF, 8'd0);
    wait_idle();
    check("cyc_low_after_read", 64'(wbm_cyc), 64'(0));

    // Four-beat write.
    for (int i = 0; i < 4; i++) dly_a[i] = $urandom_range(3);
    start_cmd(1'b1, 32'h3000_0000, 32'hA5A5_A5A5, 4'hF, 8'd3);
    wait_idle();

    // Ack on the last allowed cycle still completes.
    dly_a[0] = TMO - 1;
    rdat_a[0] = 32'hCAFE_F00D;
    start_cmd(1'b0, 32'h1000_0040, 32'h0, 4'h3, 8'd0);
    wait_idle();

    // No ack: abort after TMO request cycles.
    dly_a[0] = TMO;
    start_cmd(1'b0, 32'h2000_0000, 32'h0, 4'hF, 8'd0);
    wait_idle();

    // Abort on the second beat discards the rest.
    dly_a[0] = 0; dly_a[1] = TMO + 2; dly_a[2] = 0; dly_a[3] = 0;
    rdat_a[0] = 32'h0BAD_BEEF;
    start_cmd(1'b0, 32'h4000_0100, 32'h0, 4'hF, 8'd3);
    wait_idle();

    // Address wraps past 0xFFFFFFFC.
    dly_a[0] = 0; dly_a[1] = 2;
    rdat_a[0] = 32'h1111_1111; rdat_a[1] = 32'h2222_2222;
    start_cmd(1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 8'd1);
    wait_idle();

    // Ten cycles of back-pressure with stray acks on the bus.
    spurious = 1'b1;
    stall_cnt = 10;
    for (int i = 0; i < 3; i++) begin
      dly_a[i]  = 0;
      rdat_a[i] = $urandom;
    end
    start_cmd(1'b0, 32'h5000_0000, 32'h0, 4'hF, 8'd2);
    wait_idle();
    spurious = 1'b0;

    // Asynchronous reset during the second beat of a burst.
    for (int i = 0; i < 4; i++) dly_a[i] = 2;
    b0 = bus_done;
    start_cmd(1'b1, 32'h6000_0000, 32'h5555_AAAA, 4'hC, 8'd3);
    n = 0;
    while (!(bus_done >= b0 + 1 && wbm_stb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) note_fail("second_beat_wait");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    bus_q.delete();
    rsp_q.delete();
    resp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    dly_a[0] = 0; dly_a[1] = 1;
    rdat_a[0] = 32'h7777_0000; rdat_a[1] = 32'h7777_0001;
    start_cmd(1'b0, 32'h7000_0000, 32'h0, 4'hF, 8'd1);
    wait_idle();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] len;
      len = 8'($urandom_range(7));
      for (int i = 0; i <= int'(len); i++) begin
        dly_a[i]  = ($urandom_range(15) == 0) ? int'($urandom_range(TMO + 3, TMO)) : int'($urandom_range(4));
        rdat_a[i] = $urandom;
      end
      ready_pct = int'($urandom_range(100, 40));
      spurious  = 1'($urandom_range(1));
      start_cmd(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)), len);
      wait_idle();
    end

    check("bus_queue_drained", 64'(bus_q.size()), 64'(0));
    check("responder_queue_drained", 64'(resp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_burst_initiator.md
WB_BURST_INITIATOR -- requirements
Module: wb_burst_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the number of cycles to wait for ack before abort (1..65535).
REQ-002 SHALL have port wb_clk_i  in  1  the single clock, rising edge.
REQ-003 SHALL have port wb_rstn_i  in  1  the reset, asynchronous and active-low.
REQ-004 SHALL have ports cmd_valid_i  in  1, cmd_ready_o  out  1  for the command handshake.
REQ-005 SHALL have ports cmd_we_i  in  1, cmd_adr_i  in  32, cmd_dat_i  in  32, cmd_sel_i  in  4, cmd_len_i  in  8  for the command fields; beats = len+1.
REQ-006 SHALL have ports rsp_valid_o  out  1, rsp_ready_i  in  1  for the per-beat response handshake.
REQ-007 SHALL have ports rsp_dat_o  out  32 (read data), rsp_err_o  out  1 (timeout), rsp_last_o  out  1 (final beat).
REQ-008 SHALL have Wishbone initiator outputs wbm_cyc_o, wbm_stb_o, wbm_we_o (1 each), wbm_sel_o (4), wbm_adr_o (32), wbm_dat_o (32).
REQ-009 SHALL have Wishbone initiator inputs wbm_ack_i (1) and wbm_dat_i (32).
REQ-010 SHALL have port busy_o  out  1, high whenever the FSM is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, GAP, RESP.
REQ-012 IDLE: cmd_ready_o=1; on cmd_valid_i, latch all cmd fields, set beat counter=len, set address=cmd_adr_i, go to REQ next cycle.
REQ-013 REQ: drive cyc=stb=1, we, sel, adr, and dat (same cmd_dat_i every write beat); load the timeout counter on entry.
REQ-014 REQ with wbm_ack_i=1: capture wbm_dat_i (reads; 0 for writes) and drop stb the next cycle; go to RESP.
REQ-015 REQ without ack: decrement the timeout counter; at zero, drop cyc and stb, go to RESP with err=1 and last=1.
REQ-016 RESP: rsp_valid_o=1 with stable fields until rsp_ready_i; stb stays 0, cyc stays 1 unless aborted or last.
REQ-017 RESP on handshake: if last or err, drop cyc and go to IDLE; else decrement the beat counter, add 4 to the address (mod 2^32, wraps), go to GAP.
REQ-018 GAP: hold stb=0 for exactly one cycle, then go to REQ; this guarantees stb is low for at least one cycle between beats.
REQ-019 rsp_last_o SHALL be 1 when the beat counter is 0 or on timeout.
REQ-020 Remaining beats after a timeout SHALL be discarded with no further bus cycles.
REQ-021 An ack arriving outside REQ SHALL be ignored.
REQ-022 cmd_ready_o SHALL be 0 in every state but IDLE; no command is queued.
REQ-023 Minimum beat latency SHALL be 1 cycle in REQ if ack arrives immediately, plus RESP and GAP; back-pressure on rsp_ready_i SHALL stall without bus activity.

Reset
REQ-024 Asserting wb_rstn_i SHALL immediately force IDLE and set all outputs to 0 except cmd_ready_o=1, even mid-burst.
REQ-025 Deassertion SHALL be synchronized externally; the first command SHALL be accepted no earlier than the first edge after release.

Structure
REQ-026 A shared package wb_pkg SHALL hold the FSM state encoding, WB_ADDR_STEP=4, and the widths 32/4/8.
REQ-027 One sub-module wb_timeout_ctr (loadable down-counter with zero flag) SHALL be instantiated; everything else is flat.

Verification
REQ-028 Read, len=0, adr=0x3000_0000, responder acks after 1 cycle with 0x1234_5678 -> one response {dat=0x12345678, err=0, last=1}; cyc low afterwards.
REQ-029 Write, len=3, adr=0x3000_0000, dat=0xA5A5_A5A5, sel=0xF -> four bus beats at adr 0x30000000/04/08/0C, each with stb low ≥1 cycle between beats, and four responses with last on the 4th only.
REQ-030 Read, TIMEOUT=8, no ack -> cyc/stb drop after 8 REQ cycles; one response {err=1, last=1}; busy_o low 1 cycle after the handshake.
REQ-031 Read, len=1, adr=0xFFFF_FFFC -> second beat adr=0x0000_0000 (wrap).
REQ-032 rsp_ready_i held low 10 cycles during a burst -> rsp fields stable, stb=0, no extra acks consumed; then resumes.
REQ-033 wb_rstn_i pulsed low during the 2nd beat of a len=3 burst -> all outputs 0 asynchronously, cmd_ready_o=1, and a new command after release completes normally.
